// File: rtl/accum_pkg.sv
// Shared types for the button-driven chunked accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        LOAD = 2'b10,
        NOP  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone,
        StWaitRel
    } state_t;

endpackage

// File: rtl/run_once_sync.sv
// Two-flop synchroniser and falling-edge detector for a raw active-low push-button.
module run_once_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o,
    output logic level_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] settle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= 2'b00;
        end else begin
            s1_q     <= btn_ni;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    assign press_o = prev_q & ~s2_q;
    // The released level is only trusted once a real sample has replaced the reset value in s2_q,
    // so a button held through reset is not mistaken for a release followed by a press.
    assign level_o = s2_q & settle_q[1];

endmodule

// File: rtl/seq_accumulator.sv
// One add/sub/load/no-op per button press; add and sub ripple CHUNK bits per cycle.
module seq_accumulator
    import accum_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IN_W  = 10,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset_Clear,
    input  logic             Run_Accumulate,
    input  logic [1:0]       Mode,
    input  logic [IN_W-1:0]  SW,
    output logic [WIDTH-1:0] Acc,
    output logic             Cout,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               press;
    logic               released;
    logic [CHUNK:0]     slice_sum;
    int                 base;
    mode_t              mode;

    run_once_sync u_sync (
        .clk_i   (Clk),
        .rst_ni  (Reset_Clear),
        .btn_ni  (Run_Accumulate),
        .press_o (press),
        .level_o (released)
    );

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            state_q <= StWaitRel;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            work_q  <= '0;
            opnd_q  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        idx_d     = idx_q;
        mode      = mode_t'(Mode);
        base      = int'(idx_q) * CHUNK;
        slice_sum = {1'b0, work_q[base +: CHUNK]} + {1'b0, opnd_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (press) begin
                    unique case (mode)
                        ADD, SUB: begin
                            state_d = StAdd;
                            idx_d   = '0;
                            work_d  = acc_q;
                            sub_d   = (mode == SUB);
                            carry_d = (mode == SUB);
                            // Subtract as a + ~b + 1; carry out of 1 means no borrow.
                            opnd_d  = (mode == SUB) ? ~WIDTH'(SW) : WIDTH'(SW);
                        end
                        LOAD: begin
                            state_d = StDone;
                            acc_d   = WIDTH'(SW);
                            cout_d  = 1'b0;
                            ovf_d   = 1'b0;
                        end
                        NOP: begin
                            state_d = StDone;
                            cout_d  = 1'b0;
                        end
                    endcase
                end
            end
            StAdd: begin
                work_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
                carry_d               = slice_sum[CHUNK];
                idx_d                 = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = StDone;
                    acc_d   = work_d;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = ovf_q | (sub_q ? ~slice_sum[CHUNK] : slice_sum[CHUNK]);
                end
            end
            StDone: begin
                state_d = StWaitRel;
            end
            StWaitRel: begin
                if (released) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    assign Acc  = acc_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign Busy = (state_q == StAdd);
    assign Done = (state_q == StDone);

endmodule

// File: tb/tb_seq_accumulator.sv
// Randomised self-checking bench for seq_accumulator against an arithmetic reference model.
module tb_seq_accumulator;

    localparam int WIDTH = 16;
    localparam int IN_W  = 10;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             Clk            = 1'b0;
    logic             Reset_Clear    = 1'b0;
    logic             Run_Accumulate = 1'b1;
    logic [1:0]       Mode           = 2'b00;
    logic [IN_W-1:0]  SW             = '0;
    logic [WIDTH-1:0] Acc;
    logic             Cout;
    logic             Ovf;
    logic             Busy;
    logic             Done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int unsigned m_acc  = 0;
    int unsigned m_cout = 0;
    int unsigned m_ovf  = 0;

    always #5 Clk = ~Clk;

    seq_accumulator #(
        .WIDTH (WIDTH),
        .IN_W  (IN_W),
        .CHUNK (CHUNK)
    ) dut (
        .Clk            (Clk),
        .Reset_Clear    (Reset_Clear),
        .Run_Accumulate (Run_Accumulate),
        .Mode           (Mode),
        .SW             (SW),
        .Acc            (Acc),
        .Cout           (Cout),
        .Ovf            (Ovf),
        .Busy           (Busy),
        .Done           (Done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input int unsigned m, input int unsigned sw);
        case (m)
            0: begin
                m_cout = (m_acc + sw > 32'hFFFF) ? 1 : 0;
                m_acc  = (m_acc + sw) % 65536;
                if (m_cout == 1) m_ovf = 1;
            end
            1: begin
                m_cout = (m_acc >= sw) ? 1 : 0;
                m_acc  = (m_acc + 65536 - sw) % 65536;
                if (m_cout == 0) m_ovf = 1;
            end
            2: begin
                m_acc  = sw;
                m_cout = 0;
                m_ovf  = 0;
            end
            default: m_cout = 0;
        endcase
    endtask

    // One button press, held for hold extra cycles after Done, then released.
    task automatic do_op(input int unsigned m, input int unsigned sw, input int hold);
        int               busy_n;
        int               done_n;
        int               cyc;
        bit               scrambled;
        logic [WIDTH-1:0] acc_s;
        logic             cout_s;
        logic             ovf_s;
        busy_n    = 0;
        done_n    = 0;
        cyc       = 0;
        scrambled = 0;
        acc_s     = 'x;
        cout_s    = 1'bx;
        ovf_s     = 1'bx;
        @(negedge Clk);
        Mode           = 2'(m);
        SW             = IN_W'(sw);
        Run_Accumulate = 1'b0;
        while (done_n == 0 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            busy_n += int'(Busy);
            if (Done) begin
                done_n++;
                acc_s  = Acc;
                cout_s = Cout;
                ovf_s  = Ovf;
            end
            if ((Busy || Done) && !scrambled) begin
                scrambled = 1;
                Mode      = 2'($urandom);
                SW        = IN_W'($urandom);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            busy_n += int'(Busy);
            done_n += int'(Done);
        end
        Run_Accumulate = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            busy_n += int'(Busy);
            done_n += int'(Done);
        end
        model_op(m, sw);
        check_eq("busy_cycles", busy_n, (m < 2) ? N : 0);
        check_eq("done_pulses", done_n, 1);
        check_eq("acc", acc_s, m_acc);
        check_eq("cout", cout_s, m_cout);
        check_eq("ovf", ovf_s, m_ovf);
    endtask

    initial begin
        int cyc;
        int busy_n;
        int done_n;

        #22;
        check_eq("rst_acc", Acc, 0);
        check_eq("rst_cout", Cout, 0);
        check_eq("rst_ovf", Ovf, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_done", Done, 0);
        @(negedge Clk);
        Reset_Clear = 1'b1;
        repeat (5) @(negedge Clk);

        // Load, then repeated adds
        do_op(2, 10'h3FF, 0);
        check_eq("load_3ff", Acc, 16'h03FF);
        do_op(2, 0, 0);
        for (int i = 0; i < 3; i++) do_op(0, 3, 0);
        check_eq("three_adds", Acc, 16'h0009);

        // Long hold yields a single operation
        do_op(0, 1, 100);
        check_eq("hold_once", Acc, 16'h000A);

        // Climb to 0xFFFE without overflow, then wrap
        do_op(2, 10'h3FF, 0);
        for (int i = 0; i < 63; i++) do_op(0, 10'h3FF, 0);
        do_op(0, 10'h03E, 0);
        check_eq("reach_fffe", Acc, 16'hFFFE);
        check_eq("no_ovf_yet", Ovf, 0);
        do_op(0, 3, 0);
        check_eq("wrap_acc", Acc, 16'h0001);
        check_eq("wrap_ovf", Ovf, 1);
        do_op(0, 1, 0);
        check_eq("ovf_sticky", Ovf, 1);
        do_op(3, 0, 0);
        check_eq("nop_ovf_kept", Ovf, 1);
        do_op(2, 0, 0);
        check_eq("load_clears_ovf", Ovf, 0);

        // Subtract with and without borrow
        do_op(2, 5, 0);
        do_op(1, 7, 0);
        check_eq("sub_borrow", Acc, 16'hFFFE);
        do_op(2, 8, 0);
        do_op(1, 3, 0);
        check_eq("sub_ok", Acc, 16'h0005);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            do_op($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 3));
        end

        // Reset in the second Busy cycle with the button held
        do_op(2, 10'h155, 0);
        @(negedge Clk);
        Mode           = 2'b00;
        SW             = 10'h005;
        Run_Accumulate = 1'b0;
        cyc            = 0;
        while (!Busy && cyc < 20) begin
            @(negedge Clk);
            cyc++;
        end
        @(negedge Clk);
        check_eq("second_busy", Busy, 1);
        Reset_Clear = 1'b0;
        #1;
        check_eq("arst_acc", Acc, 0);
        check_eq("arst_cout", Cout, 0);
        check_eq("arst_ovf", Ovf, 0);
        check_eq("arst_busy", Busy, 0);
        check_eq("arst_done", Done, 0);
        m_acc  = 0;
        m_cout = 0;
        m_ovf  = 0;
        repeat (2) @(negedge Clk);
        Reset_Clear = 1'b1;
        busy_n      = 0;
        done_n      = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            busy_n += int'(Busy);
            done_n += int'(Done);
        end
        check_eq("held_busy", busy_n, 0);
        check_eq("held_done", done_n, 0);
        check_eq("held_acc", Acc, 0);
        Run_Accumulate = 1'b1;
        repeat (6) @(negedge Clk);
        do_op(0, 7, 0);
        check_eq("after_rst_add", Acc, 16'h0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
